sccb_target_responder: RTL

//   SCCB/I2C target (slave) that answers the bus side of our 2-byte-address

---
 rtl/sccb_target_responder.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/sccb_target_responder.sv
// SCCB/I2C register target for the 2-byte-address sensor configuration master.
// Define SCCB_RESP_READ_EN to add the register file and serve read transactions.
module sccb_target_responder #(
  parameter logic [6:0] DEV_ADDR   = 7'h3C,
  parameter int         REGFILE_AW = 8,
  parameter int         FILTER_LEN = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  output logic        wr_strobe,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy
);

  localparam logic [3:0] S_IDLE    = 4'd0,  S_DEV    = 4'd1,  S_DEV_ACK = 4'd2,
                         S_AH      = 4'd3,  S_AH_ACK = 4'd4,  S_AL      = 4'd5,
                         S_AL_ACK  = 4'd6,  S_WR     = 4'd7,  S_WR_ACK  = 4'd8,
                         S_RD      = 4'd9,  S_RD_MACK = 4'd10;

`ifdef SCCB_RESP_READ_EN
  localparam bit READ_EN = 1'b1;
`else
  localparam bit READ_EN = 1'b0;
`endif

  // index 1 = SCL, index 0 = SDA; idle bus is high, so everything resets to 1
  logic [1:0]                 sync1, sync2, filt, filt_q;
  logic [1:0][FILTER_LEN-1:0] hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= '1;
      sync2  <= '1;
      hist   <= '1;
      filt   <= '1;
      filt_q <= '1;
    end else begin
      sync1  <= {scl_i, sda_i};
      sync2  <= sync1;
      filt_q <= filt;
      for (int i = 0; i < 2; i++) begin
        hist[i] <= {hist[i][FILTER_LEN-2:0], sync2[i]};
        if (&hist[i])       filt[i] <= 1'b1;
        else if (~|hist[i]) filt[i] <= 1'b0;
      end
    end
  end

  logic scl, sda, start_ev, stop_ev, rise, fall;
  assign scl      = filt[1];
  assign sda      = filt[0];
  assign start_ev = scl & filt_q[1] & filt_q[0] & ~sda;
  assign stop_ev  = scl & filt_q[1] & ~filt_q[0] & sda;
  assign rise     = scl & ~filt_q[1];
  assign fall     = ~scl & filt_q[1];

  logic [3:0]  state, bit_cnt;
  logic [6:0]  sr;
  logic [7:0]  tx, rx_byte, rd_word;
  logic [15:0] ptr;
  logic        ack_ph, rw;

  assign rx_byte = {sr, sda};

`ifdef SCCB_RESP_READ_EN
  logic [7:0] regfile [2**REGFILE_AW];
  assign rd_word = regfile[ptr[REGFILE_AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**REGFILE_AW; i++) regfile[i] <= '0;
    end else if (wr_strobe) begin
      regfile[wr_addr[REGFILE_AW-1:0]] <= wr_data;
    end
  end
`else
  assign rd_word = 8'h00;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      sr        <= '0;
      tx        <= '0;
      ptr       <= '0;
      ack_ph    <= 1'b0;
      rw        <= 1'b0;
      sda_oe    <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      if (start_ev) begin
        busy    <= 1'b1;
        state   <= S_DEV;
        bit_cnt <= '0;
        ack_ph  <= 1'b0;
        sda_oe  <= 1'b0;
      end else if (stop_ev) begin
        busy   <= 1'b0;
        state  <= S_IDLE;
        ack_ph <= 1'b0;
        sda_oe <= 1'b0;
      end else begin
        case (state)
          S_DEV, S_AH, S_AL, S_WR: if (rise) begin
            sr      <= rx_byte[6:0];
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt <= '0;
              case (state)
                S_DEV: begin
                  // a mismatched address, or a read without a register file, is simply not ACKed
                  if (rx_byte[7:1] == DEV_ADDR && (!rx_byte[0] || READ_EN)) begin
                    state <= S_DEV_ACK;
                    rw    <= rx_byte[0];
                    tx    <= rd_word;
                  end else begin
                    state <= S_IDLE;
                  end
                end
                S_AH: begin
                  ptr[15:8] <= rx_byte;
                  state     <= S_AH_ACK;
                end
                S_AL: begin
                  ptr[7:0] <= rx_byte;
                  state    <= S_AL_ACK;
                end
                default: begin
                  wr_strobe <= 1'b1;
                  wr_addr   <= ptr;
                  wr_data   <= rx_byte;
                  ptr       <= ptr + 16'd1;
                  state     <= S_WR_ACK;
                end
              endcase
            end
          end
          // first SCL fall opens the ACK slot, second closes it
          S_DEV_ACK, S_AH_ACK, S_AL_ACK, S_WR_ACK: if (fall) begin
            if (!ack_ph) begin
              ack_ph <= 1'b1;
              sda_oe <= 1'b1;
            end else begin
              ack_ph <= 1'b0;
              sda_oe <= 1'b0;
              case (state)
                S_DEV_ACK: if (rw) begin
                  state  <= S_RD;
                  sda_oe <= ~tx[7];
                end else begin
                  state <= S_AH;
                end
                S_AH_ACK: state <= S_AL;
                default:  state <= S_WR;
              endcase
            end
          end
          S_RD: begin
            if (rise) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (fall) begin
              if (bit_cnt == 4'd8) begin
                bit_cnt <= '0;
                sda_oe  <= 1'b0;
                ptr     <= ptr + 16'd1;
                state   <= S_RD_MACK;
              end else begin
                tx     <= {tx[6:0], 1'b0};
                sda_oe <= ~tx[6];
              end
            end
          end
          S_RD_MACK: begin
            if (rise) begin
              if (sda) state <= S_IDLE;
              else     tx    <= rd_word;
            end else if (fall) begin
              state  <= S_RD;
              sda_oe <= ~tx[7];
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
